// File: rtl/id_scan_ctrl.sv
// Identifier scanner: splits an ASCII character stream into tokens on
// separator characters and reports each token's length (saturating) and
// whether it is a well-formed identifier. Results are handed off through
// a single-entry valid/ready output register.
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | no token open, waiting for a non-separator
// IN_ID  | token open, everything so far fits identifier
// IN_BAD | token open, already known not an identifier
module id_scan_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [7:0] in_char,
   input  logic       in_last,
   output logic       in_ready,
   output logic       tok_valid,
   output logic [4:0] tok_len,
   output logic       tok_is_id,
   input  logic       out_ready,
   output logic [7:0] id_count,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, IN_ID, IN_BAD} state_t;

   state_t     state;
   logic [4:0] len;

   logic       xfer;
   logic       is_letter;
   logic       is_digit;
   logic       is_sep;
   logic [4:0] len_inc;
   logic       id_next;
   logic       emit;
   logic [4:0] emit_len;
   logic       emit_id;

   // Output handshake: a pending result only stalls input when it is not being taken.
   assign in_ready = !tok_valid || out_ready;
   assign xfer     = in_valid && in_ready;
   assign busy     = (state != IDLE) || tok_valid;

   // Character classification and next-token bookkeeping.
   always_comb begin
      is_letter = ((in_char >= 8'h41) && (in_char <= 8'h5A)) ||
                  ((in_char >= 8'h61) && (in_char <= 8'h7A));
      is_digit  = (in_char >= 8'h30) && (in_char <= 8'h39);
      is_sep    = (in_char == 8'h00) || (in_char == 8'h09) || (in_char == 8'h0A) ||
                  (in_char == 8'h0D) || (in_char == 8'h20);

      len_inc = 5'd1;
      id_next = is_letter;
      if (state != IDLE) begin
         len_inc = (len == 5'd31) ? 5'd31 : len + 5'd1;
         id_next = (state == IN_ID) && (is_letter || is_digit);
      end

      // A separator closes an open token; in_last closes after the char is folded in.
      emit     = xfer && ((is_sep && (state != IDLE)) || (!is_sep && in_last));
      emit_len = is_sep ? len : len_inc;
      emit_id  = is_sep ? (state == IN_ID) : id_next;
   end

   // Scanner FSM, length counter and registered result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         len       <= 5'd0;
         tok_valid <= 1'b0;
         tok_len   <= 5'd0;
         tok_is_id <= 1'b0;
         id_count  <= 8'd0;
      end else begin
         if (xfer) begin
            if (is_sep || in_last) begin
               state <= IDLE;
               len   <= 5'd0;
            end else begin
               state <= id_next ? IN_ID : IN_BAD;
               len   <= len_inc;
            end
         end

         if (emit) begin
            tok_valid <= 1'b1;
            tok_len   <= emit_len;
            tok_is_id <= emit_id;
            if (emit_id && (id_count != 8'd255))
               id_count <= id_count + 8'd1;
         end else if (tok_valid && out_ready) begin
            tok_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_id_scan_ctrl.sv
// Bench for id_scan_ctrl: a token-level reference model (character queue
// per open token, classification by scanning the queue) checked against
// the DUT on every cycle, plus directed scenarios with literal expectations.
module tb_id_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_char = 8'h00;
   logic       in_last = 1'b0;
   logic       in_ready;
   logic       tok_valid;
   logic [4:0] tok_len;
   logic       tok_is_id;
   logic       out_ready = 1'b0;
   logic [7:0] id_count;
   logic       busy;

   int total = 0;
   int bad   = 0;

   id_scan_ctrl dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_char(in_char),
      .in_last(in_last), .in_ready(in_ready), .tok_valid(tok_valid),
      .tok_len(tok_len), .tok_is_id(tok_is_id), .out_ready(out_ready),
      .id_count(id_count), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic bit f_letter(input logic [7:0] c);
      return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
   endfunction

   function automatic bit f_digit(input logic [7:0] c);
      return c >= "0" && c <= "9";
   endfunction

   function automatic bit f_sep(input logic [7:0] c);
      return c == 8'h00 || c == 8'h09 || c == 8'h0A || c == 8'h0D || c == 8'h20;
   endfunction

   function automatic bit f_ident(input logic [7:0] q[$]);
      if (q.size() == 0 || !f_letter(q[0])) return 1'b0;
      for (int i = 1; i < q.size(); i++)
         if (!(f_letter(q[i]) || f_digit(q[i]))) return 1'b0;
      return 1'b1;
   endfunction

   // reference model state
   logic [7:0] tq[$];
   bit         m_valid;
   int         m_len;
   bit         m_id;
   int         m_cnt;
   bit         m_xfer;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tq.delete();
         m_valid = 0; m_len = 0; m_id = 0; m_cnt = 0; m_xfer = 0;
      end else begin
         bit emit;
         emit = 0;
         m_xfer = in_valid && (!m_valid || out_ready);
         if (m_xfer) begin
            if (!f_sep(in_char)) tq.push_back(in_char);
            if ((f_sep(in_char) || in_last) && tq.size() > 0) emit = 1;
         end
         if (emit) begin
            m_valid = 1;
            m_len   = (tq.size() > 31) ? 31 : tq.size();
            m_id    = f_ident(tq);
            if (m_id && m_cnt < 255) m_cnt++;
            tq.delete();
         end else if (m_valid && out_ready) begin
            m_valid = 0;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      chk("in_ready", int'(in_ready), int'(!m_valid || out_ready));
      chk("tok_valid", int'(tok_valid), int'(m_valid));
      chk("id_count", int'(id_count), m_cnt);
      chk("busy", int'(busy), int'(tq.size() > 0 || m_valid));
      if (m_valid) begin
         chk("tok_len", int'(tok_len), m_len);
         chk("tok_is_id", int'(tok_is_id), int'(m_id));
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0; in_last = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic feed(input string s, input bit last);
      for (int i = 0; i < s.len(); i++) begin
         int n;
         in_valid = 1'b1;
         in_char  = s[i];
         in_last  = last && (i == s.len() - 1);
         n = 0;
         do begin
            @(posedge clk); #1;
            n++;
         end while (!m_xfer && n < 100);
         if (!m_xfer) chk("feed_timeout", 0, 1);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   function automatic logic [7:0] rand_char();
      logic [7:0] seps[5]   = '{8'h00, 8'h09, 8'h0A, 8'h0D, 8'h20};
      logic [7:0] others[10] = '{8'h5F, 8'h21, 8'h2F, 8'h3A, 8'h40, 8'h5B,
                                 8'h60, 8'h7B, 8'h7F, 8'hC8};
      int r;
      r = $urandom_range(0, 99);
      if (r < 25) return 8'h61 + 8'($urandom_range(0, 25));
      if (r < 40) return 8'h41 + 8'($urandom_range(0, 25));
      if (r < 60) return 8'h30 + 8'($urandom_range(0, 9));
      if (r < 78) return seps[$urandom_range(0, 4)];
      return others[$urandom_range(0, 9)];
   endfunction

   initial begin
      #1;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_tok_valid", int'(tok_valid), 0);
      chk("rst_busy", int'(busy), 0);
      do_reset();

      // "ab12 "
      out_ready = 1'b1;
      feed("ab12 ", 0);
      chk("ab12_valid", int'(tok_valid), 1);
      chk("ab12_len", int'(tok_len), 4);
      chk("ab12_id", int'(tok_is_id), 1);
      chk("ab12_cnt", int'(id_count), 1);

      // "1a_ ab "
      do_reset();
      feed("1a_ ", 0);
      chk("bad_len", int'(tok_len), 3);
      chk("bad_id", int'(tok_is_id), 0);
      feed("ab ", 0);
      chk("ab_len", int'(tok_len), 2);
      chk("ab_id", int'(tok_is_id), 1);
      chk("ab_cnt", int'(id_count), 1);

      // back-pressure
      do_reset();
      out_ready = 1'b0;
      feed("x ", 0);
      in_valid = 1'b1; in_char = "y";
      repeat (5) @(posedge clk);
      #1;
      chk("stall_ready", int'(in_ready), 0);
      chk("stall_valid", int'(tok_valid), 1);
      chk("stall_len", int'(tok_len), 1);
      chk("stall_id", int'(tok_is_id), 1);
      out_ready = 1'b1;
      feed("y ", 0);
      chk("y_valid", int'(tok_valid), 1);
      chk("y_len", int'(tok_len), 1);
      chk("y_cnt", int'(id_count), 2);

      // length saturation
      do_reset();
      for (int i = 0; i < 40; i++) feed("a", 0);
      feed(" ", 0);
      chk("sat_len", int'(tok_len), 31);
      chk("sat_id", int'(tok_is_id), 1);

      // in_last close, then reset mid-token
      do_reset();
      feed("abc", 1);
      chk("last_valid", int'(tok_valid), 1);
      chk("last_len", int'(tok_len), 3);
      chk("last_id", int'(tok_is_id), 1);
      @(posedge clk); #1;
      chk("last_idle_busy", int'(busy), 0);
      feed("ab", 0);
      chk("mid_busy", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("mr_valid", int'(tok_valid), 0);
      chk("mr_len", int'(tok_len), 0);
      chk("mr_id", int'(tok_is_id), 0);
      chk("mr_busy", int'(busy), 0);
      chk("mr_ready", int'(in_ready), 1);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("mr_after_valid", int'(tok_valid), 0);
      chk("mr_after_cnt", int'(id_count), 0);

      // id_count saturation
      do_reset();
      for (int i = 0; i < 255; i++) feed("q ", 0);
      chk("cnt_255", int'(id_count), 255);
      feed("q ", 0);
      chk("cnt_hold", int'(id_count), 255);

      // randomized traffic
      do_reset();
      for (int it = 0; it < 4000; it++) begin
         if (it == 2000) do_reset();
         in_valid  = $urandom_range(0, 3) != 0;
         in_char   = (it >= 1000 && it < 1300 && $urandom_range(0, 40) != 0)
                     ? 8'h61 + 8'($urandom_range(0, 25)) : rand_char();
         in_last   = $urandom_range(0, 19) == 0;
         out_ready = $urandom_range(0, 2) != 0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/id_scan_ctrl.md
ID_SCAN_CTRL -- requirements
Module: id_scan_ctrl

Interface
REQ-001 SHALL have one clock and asynchronous active-low reset; all state on rising clk edge.
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  in_char holds a character this cycle.
REQ-005 in_char  input  8  ASCII character.
REQ-006 in_last  input  1  qualifies in_char as final character of stream; meaningful only with in_valid.
REQ-007 in_ready  output  1  block accepts in_char this cycle.
REQ-008 tok_valid  output  1  token result pending.
REQ-009 tok_len  output  5  token length, saturating at 31.
REQ-010 tok_is_id  output  1  token is an identifier.
REQ-011 out_ready  input  1  consumer accepts token result.
REQ-012 id_count  output  8  identifiers emitted since reset, saturating at 255.
REQ-013 busy  output  1  high in any state other than IDLE, or while tok_valid is high.

Function
REQ-014 Character accepted only when in_valid && in_ready (transfer).
REQ-015 Classes: LETTER = 0x41-0x5A or 0x61-0x7A; DIGIT = 0x30-0x39; SEP = 0x00, 0x09, 0x0A, 0x0D, 0x20; OTHER = all remaining codes.
REQ-016 Token = maximal run of non-SEP characters; identifier = first char LETTER, all later chars LETTER or DIGIT.
REQ-017 FSM states: IDLE (no open token), IN_ID (open token, still identifier), IN_BAD (open token, not identifier).
REQ-018 IDLE: LETTER -> IN_ID, len=1; DIGIT/OTHER -> IN_BAD, len=1; SEP -> stay IDLE, no output.
REQ-019 IN_ID: LETTER/DIGIT -> stay, len+1; OTHER -> IN_BAD, len+1; SEP -> emit token (is_id=1), -> IDLE.
REQ-020 IN_BAD: non-SEP -> stay, len+1; SEP -> emit token (is_id=0), -> IDLE.
REQ-021 Length counter SHALL saturate at 31; further characters still extend token and affect classification.
REQ-022 Emit: tok_len/tok_is_id registered, tok_valid set the cycle after terminating transfer; SEP not counted in length.
REQ-023 Transfer with in_last=1 SHALL close the open token after including a non-SEP final char (len+1, class applied), emit it, and return to IDLE; in_last on SEP in IDLE emits nothing.
REQ-024 tok_valid, tok_len, tok_is_id SHALL hold stable until tok_valid && out_ready; tok_valid clears the next cycle unless a new emit occurs that same cycle.
REQ-025 in_ready = !tok_valid || out_ready (a pending result stalls input only if not being consumed); emit and consume in same cycle SHALL load the new result with tok_valid held high.
REQ-026 id_count SHALL increment by 1 at each emit with is_id=1, saturating at 255, never wrapping.
REQ-027 No transfer cycle: FSM, length and outputs unchanged.
REQ-028 Latency: terminating transfer at cycle N -> tok_valid high at N+1.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, len=0, tok_valid=0, tok_len=0, tok_is_id=0, id_count=0, busy=0; in_ready=1 during and after reset.
REQ-030 Reset mid-token or with tok_valid pending SHALL discard the partial token and pending result with no emission.

Verification
REQ-031 Stream "ab12 " with out_ready=1 -> one result tok_len=4, tok_is_id=1 one cycle after space; id_count=1.
REQ-032 Stream "1a_ ab " -> first result len=3 is_id=0, second len=2 is_id=1; id_count=1.
REQ-033 "x " then "y " with out_ready=0 for 5 cycles -> tok_valid=1 holding len=1 is_id=1 (x), in_ready=0 while stalled; after out_ready=1 second result (y) appears; id_count=2.
REQ-034 40 consecutive 'a' then space -> tok_len=31, tok_is_id=1.
REQ-035 "abc" with in_last on 'c' -> len=3 is_id=1 next cycle, FSM IDLE; separately, rst_n low after "ab" -> no result, all outputs zero.
REQ-036 256 single-letter identifiers -> id_count=255 stays 255.
